data_memory: RTL and testbench
==============================

# data_memory

Parametrised byte-addressed data memory for the processor's load/store stage. It supersedes the fixed 2 KB word-only memory. It adds byte, half-word and word accesses with sign/zero extension, a valid/ready request handshake, a one-cycle registered response with fault reporting, and a post-reset clear sweep. Storage is little-endian: byte at `addr` occupies lane `addr[1:0]` of word `addr>>2`.

## Interface
Parameters:
- `DEPTH_BYTES`, default 2048: memory size in bytes. Must be a power of two and at least 4.
- `CLEAR_ON_RESET`, default 1: when 1, all words are zeroed after reset. When 0, the block goes straight to IDLE.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  **asynchronous, active-low** reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified (byte uses [7:0], half uses [15:0]).
- `rsp_valid`  out  1  one-cycle pulse; response for the request accepted on the previous edge.
- `rsp_data`  out  32  load result. It is 0 for stores and for faults.
- `rsp_fault`  out  1  the accepted request was rejected.

## Operation
- The FSM has two states, CLEAR and IDLE.
- **CLEAR** (entered on reset release when `CLEAR_ON_RESET`=1):
  - A word index runs from 0 to DEPTH_BYTES/4−1 and writes 0 to one word per cycle.
  - `req_ready`=0 throughout.
  - After the last word the FSM moves to IDLE.
- **IDLE**: `req_ready`=1. A request is accepted on any edge where `req_valid`&&`req_ready`. One request per cycle, with no bubbles.
- **Fault** is raised on any of the following:
  - `req_size`=11;
  - half access with `addr[0]`≠0;
  - word access with `addr[1:0]`≠0;
  - `addr` ≥ DEPTH_BYTES. All 32 bits are compared; there is no aliasing.
- **Fault effects:** no memory write, `rsp_fault`=1, `rsp_data`=0.
- **Store:**
  - Only the addressed lanes are written: byte writes 1 lane, half writes lanes {addr[1],0} and {addr[1],1}, word writes all 4.
  - Other lanes are unchanged.
  - The response is `rsp_valid`=1, `rsp_data`=0, `rsp_fault`=0.
- **Load:**
  - The addressed lanes are read and right-justified.
  - Bits above the access width are filled with the MSB of the loaded value when `req_signed`=1, otherwise with 0.
  - `req_signed` is ignored for word loads.
- There is no response backpressure; the consumer must take `rsp_*` in the cycle `rsp_valid`=1.

## Timing
- **Latency:** request accepted at edge N; `rsp_valid`/`rsp_data`/`rsp_fault` are valid from edge N+1 until edge N+2.
- **Outputs when idle:** in every cycle without a response, `rsp_valid`=0, and `rsp_data`/`rsp_fault` are held at 0.
- **Store then load, back-to-back:** a store accepted at edge N commits at edge N. A load to the same address accepted at edge N+1 returns the new data. No forwarding logic is needed.
- **Clear sweep length:** DEPTH_BYTES/4 cycles, i.e. 512 cycles at the default size. `req_ready` rises in the cycle after the last clear write.
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_fault`=0, FSM in CLEAR (or IDLE if `CLEAR_ON_RESET`=0), clear index 0.
- **Reset asserted mid-operation:**
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - Any pending response is dropped.
  - A partially completed sweep restarts from word 0.
  - A request on the same edge as reset assertion is not performed.
- The clear index must be sized as log2(DEPTH_BYTES/4) bits, plus one terminal bit if the implementation needs it.

## Structure
- Package `data_memory_pkg` holds:
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_ILLEGAL`;
  - the FSM state enum (`ST_CLEAR`, `ST_IDLE`);
  - a helper function that computes the 4-bit lane mask from size and `addr[1:0]`.
- Sub-module `mem_load_align` is purely combinational. It takes the 32-bit word, `addr[1:0]`, size and signed, and returns the extended result.
- Storage is a word array of DEPTH_BYTES/4 × 32 bits with per-lane write enables. It is not reset by `reset`; zeroing happens only through the sweep.

## Test plan
- **Reset and clear:** reset low 3 cycles then high. Expect `req_ready`=0 for exactly 512 cycles, then 1. A word load at 0x7FC returns 0x00000000 with `rsp_fault`=0.
- **Word store, byte loads:** word store 0xDEADBEEF @0x10. Unsigned byte loads at 0x10..0x13 return 0xEF, 0xBE, 0xAD, 0xDE. A signed byte load at 0x13 returns 0xFFFFFFDE.
- **Half store:** half store 0x00008001 @0x12. Word load at 0x10 returns 0x8001BEEF. Signed half load at 0x12 returns 0xFFFF8001; unsigned returns 0x00008001.
- **Faults:**
  - word load @0x11 → fault, data 0;
  - word store @0x800 → fault;
  - size 11 → fault;
  - a subsequent word load at 0x10 still returns 0x8001BEEF.
- **Back-to-back traffic:** `req_valid` held high, alternating store/load to 0x20 with incrementing data. `rsp_valid`=1 every cycle, and each load returns the value stored one cycle earlier.
- **Reset mid-traffic:** drive `reset` low mid-traffic and again at clear-sweep cycle 100. Outputs drop to 0 asynchronously, the sweep restarts at word 0 (512 more cycles), and afterwards address 0x10 reads 0.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM state type and lane-mask helper for the byte-addressed data memory.
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Byte lanes touched by an access of the given size at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_BYTE: mask = 4'b0001 << lane;
            SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// Right-justifies the addressed lanes of a memory word and applies sign or zero extension.
module mem_load_align
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        result  = 32'h0;
        case (size)
            SZ_BYTE: result = is_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
            SZ_HALF: result = is_signed ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'h0, shifted[15:0]};
            SZ_WORD: result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with valid/ready requests, one-cycle
// registered responses, fault reporting and an optional post-reset zeroing sweep.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_BYTES    = 2048,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORDS - 1);
    localparam logic [31:0]      DEPTH_LIMIT = 32'(DEPTH_BYTES);

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    logic [31:0]      mem [WORDS];

    logic             accept;
    logic             fault;
    logic [IDX_W-1:0] req_widx;
    logic [3:0]       req_mask;
    logic [31:0]      req_lanes;
    logic [31:0]      rd_word;
    logic [31:0]      load_result;

    logic [3:0]       mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;

    assign accept   = req_valid && req_ready;
    assign req_widx = req_addr[IDX_W+1:2];
    assign req_mask = lane_mask(req_size, req_addr[1:0]);
    assign rd_word  = mem[req_widx];

    // The full 32-bit address is range-checked so out-of-range accesses never alias.
    always_comb begin
        fault = 1'b0;
        if (req_size == SZ_ILLEGAL)
            fault = 1'b1;
        if (req_size == SZ_HALF && req_addr[0] != 1'b0)
            fault = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            fault = 1'b1;
        if (req_addr >= DEPTH_LIMIT)
            fault = 1'b1;
    end

    always_comb begin
        req_lanes = req_wdata;
        case (req_size)
            SZ_BYTE: req_lanes = {4{req_wdata[7:0]}};
            SZ_HALF: req_lanes = {2{req_wdata[15:0]}};
            default: req_lanes = req_wdata;
        endcase
    end

    // The sweep and stores share one write port; they never overlap since ready is low while clearing.
    always_comb begin
        mem_we    = 4'b0000;
        mem_widx  = '0;
        mem_wdata = 32'h0;
        if (state == ST_CLEAR) begin
            mem_we    = 4'b1111;
            mem_widx  = clr_idx;
            mem_wdata = 32'h0;
        end else if (accept && req_wen && !fault) begin
            mem_we    = req_mask;
            mem_widx  = req_widx;
            mem_wdata = req_lanes;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_we[l])
                mem[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    mem_load_align u_align (
        .word      (rd_word),
        .lane      (req_addr[1:0]),
        .size      (req_size),
        .is_signed (req_signed),
        .result    (load_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_idx   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_fault <= accept && fault;
            rsp_data  <= (accept && !fault && !req_wen) ? load_result : 32'h0;
            case (state)
                ST_CLEAR: begin
                    req_ready <= 1'b0;
                    clr_idx   <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state     <= ST_IDLE;
                        clr_idx   <= '0;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed requests push expected responses, a monitor pops and compares.
module tb_data_memory;
    import data_memory_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = SZ_WORD;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    data_memory #(.DEPTH_BYTES(2048), .CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every response is matched against the oldest expectation; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (reset) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput({e.name, "_data"}, rsp_data, e.data);
                    checkOutput({e.name, "_fault"}, 32'(rsp_fault), 32'(e.fault));
                end
            end else if (rsp_data !== 32'h0 || rsp_fault !== 1'b0) begin
                checkOutput("idle_outputs", {rsp_data[31:1], rsp_data[0] | rsp_fault}, 32'h0);
            end
        end
    end

    task automatic applyStimulus(input string name, input logic wen, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data, input logic exp_fault);
        logic ready_seen;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        ready_seen = req_ready;
        @(posedge clk);
        if (ready_seen) begin
            e.name  = name;
            e.data  = exp_data;
            e.fault = exp_fault;
            sb.push_back(e);
        end else begin
            checkOutput({name, "_ready"}, 32'(ready_seen), 32'h1);
        end
        #1;
        checkOutput({name, "_pulse"}, 32'(rsp_valid), 32'h1);
    endtask

    task automatic idleBus(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Counts cycles from reset release until ready rises, bounded.
    task automatic waitClear(input string name);
        int cnt;
        cnt = 0;
        while (!req_ready && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput(name, 32'(cnt), 32'd512);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset and clear sweep
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_data", rsp_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        waitClear("clear_cycles");
        applyStimulus("ld_7fc", 1'b0, SZ_WORD, 1'b0, 32'h7FC, 32'h0, 32'h0, 1'b0);
        idleBus(2);

        // Word store then byte loads
        applyStimulus("st_w10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus("ldbu_10", 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'h000000EF, 1'b0);
        applyStimulus("ldbu_11", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h000000BE, 1'b0);
        applyStimulus("ldbu_12", 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 32'h000000AD, 1'b0);
        applyStimulus("ldbu_13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        applyStimulus("ldbs_13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        applyStimulus("ldbs_11", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);

        // Half store merges into the upper lanes only
        applyStimulus("st_h12", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00008001, 32'h0, 1'b0);
        applyStimulus("ldw_10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
        applyStimulus("ldhs_12", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        applyStimulus("ldhu_12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00008001, 1'b0);
        applyStimulus("ldhs_10", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        applyStimulus("ldws_10", 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);

        // Faults leave memory untouched
        applyStimulus("flt_ldw_11", 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        applyStimulus("flt_ldh_13", 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        applyStimulus("flt_stw_800", 1'b1, SZ_WORD, 1'b0, 32'h800, 32'h11223344, 32'h0, 1'b1);
        applyStimulus("flt_size3", 1'b1, SZ_ILLEGAL, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1);
        applyStimulus("flt_alias", 1'b1, SZ_BYTE, 1'b0, 32'h80000010, 32'h00000077, 32'h0, 1'b1);
        applyStimulus("ldw_10_post", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);
        applyStimulus("ldw_7fc_last", 1'b0, SZ_WORD, 1'b0, 32'h7FC, 32'h0, 32'h0, 1'b0);
        idleBus(2);

        // Back-to-back store/load with valid held high
        for (int k = 1; k <= 6; k++) begin
            applyStimulus($sformatf("b2b_st%0d", k), 1'b1, SZ_WORD, 1'b0, 32'h20,
                          32'hA5000000 + 32'(k), 32'h0, 1'b0);
            applyStimulus($sformatf("b2b_ld%0d", k), 1'b0, SZ_WORD, 1'b0, 32'h20,
                          32'h0, 32'hA5000000 + 32'(k), 1'b0);
        end

        // Reset mid-traffic: pending load response must vanish immediately
        applyStimulus("pre_rst_st", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0);
        applyStimulus("pre_rst_ld", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("async_ready", 32'(req_ready), 32'h0);
        sb.delete();
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("sweep_rst_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        waitClear("clear_restart_cycles");
        applyStimulus("ldw_10_cleared", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        applyStimulus("ldw_20_cleared", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        idleBus(3);
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
